sprite_fetch_arbiter: RTL and testbench
=======================================

# sprite_fetch_arbiter

Shares the single 7-sprite, 4-pixel-per-word sprite ROM (1024 words per sprite, fixed read latency) between several reel/overlay renderers. Accepts burst fetch requests (sprite index, start word, length), arbitrates between requesters, and issues one ROM word address per cycle. It tags each issued read and routes the returned 16-bit words back to the owning requester with a per-word valid and a last-word flag. It sits between the reel renderers and the sprite ROM wrapper in the VGA pipeline.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters (2..4).
- `ROM_LATENCY`, 2: cycles from ROM address presented to `rom_data_i` valid.

Ports:
- `clk`  in  1  pixel/system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  one-hot accept pulse.
- `req_sprite_i`  in  3*NUM_REQ  sprite index per requester, slice i = [3i+2:3i].
- `req_addr_i`  in  10*NUM_REQ  start word address per requester.
- `req_len_i`  in  4*NUM_REQ  burst length minus 1; 0 = 1 word, 15 = 16 words (one 64-pixel row).
- `rom_sprite_sel_o`  out  3  to ROM sprite select, registered.
- `rom_word_addr_o`  out  10  to ROM word address, registered.
- `rom_data_i`  in  16  ROM read data.
- `rsp_valid_o`  out  NUM_REQ  one-hot: `rsp_data_o` belongs to requester i.
- `rsp_data_o`  out  16  returned word, shared by all requesters.
- `rsp_last_o`  out  1  final word of the burst.
- `busy_o`  out  1  FSM in ISSUE or any read in flight.

## Operation
- FSM states: IDLE, ISSUE.
- **IDLE:**
  - If any `req_valid_i` is set, select a winner and pulse its `req_ready_o` for one cycle.
  - Latch the winner's sprite, address and length, plus the winner id. Go to ISSUE.
  - No valid request: stay in IDLE, all `req_ready_o` low.
- **ISSUE:**
  - Each cycle, drive the latched sprite and the current address on the ROM outputs, then increment the address and decrement the remaining count.
  - The cycle that issues the final word returns the FSM to IDLE.
- **Address arithmetic:** modulo 1024. Address 1023 + 1 wraps to 0 within the same sprite; the sprite index is never incremented.
- **Sprite index 7:** forwarded unchanged; the ROM returns 0 and the words are delivered normally.
- **Tag pipeline:** `ROM_LATENCY` stages, each holding {valid, id, last}. An entry is pushed on every ISSUE cycle and aligned with `rom_data_i` at the output.
- **Arbitration:** round-robin. The search starts at (last winner + 1) mod NUM_REQ. The last-winner pointer resets to NUM_REQ-1, so requester 0 wins first.
- **Requester rules:** a requester must hold its request fields stable while valid and ready is low. Deasserting valid before ready is allowed and drops the request.
- **Non-preemptive:** a burst always runs to completion.

## Timing
- **Accept to first response:** accept (ready pulse) in cycle T. First address on `rom_word_addr_o` in T+1, last address in T+1+len. Responses appear in T+1+ROM_LATENCY .. T+1+ROM_LATENCY+len, one word per cycle with no gaps.
- **Back-to-back bursts:** the FSM is back in IDLE at T+2+len, so the earliest next accept is T+2+len. This gives one idle ROM cycle between bursts. Responses of consecutive bursts never overlap.
- **`rsp_last_o`:** high only in the same cycle as the final word's `rsp_valid_o`.
- **`rsp_valid_o`:** at most one bit set per cycle; `rsp_data_o` is `rom_data_i` passed straight through (no added latency).
- **Reset values:**
  - All outputs 0; FSM IDLE.
  - Tag pipeline cleared; round-robin pointer NUM_REQ-1.
- **Reset mid-burst:** asynchronous clear takes effect immediately. In-flight reads are discarded and no `rsp_valid_o` appears after reset deasserts. After deassertion, the first accept is possible on the first clock edge.
- **Simultaneous new request and completing burst:** the new request is accepted only in IDLE, i.e. the cycle after the final issue.

## Configuration
- `SPRITE_FETCH_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. The round-robin pointer is not implemented.
- `SPRITE_FETCH_FIXED_PRIO_EN` not defined: round-robin as described above.
- Handshake, timing and responses are identical in both modes.

## Test plan
- **Single burst:** requester 1 requests sprite 2, addr 0x010, len 15. Expect ready[1] in T, addresses 0x010..0x01F in T+1..T+16, 16 words with rsp_valid=3'b010 in T+3..T+18, rsp_last in T+18.
- **Contention:** all 3 requesters raise valid together with len 0. Expect grant order 0,1,2. Accepts at cycles T, T+2, T+4. rsp_valid one-hot per word, never two bits set.
- **Wrap:** addr 0x3FE, len 3. Expect addresses 0x3FE, 0x3FF, 0x000, 0x001 with sprite select unchanged.
- **Reset mid-burst:** assert reset_n low in the 5th issue cycle of a 16-word burst. Expect all outputs 0 immediately and no rsp_valid after release. A new request is accepted on the first edge.
- **Fairness:** requesters 0 and 2 hold valid continuously. Expect alternating grants 0,2,0,2.
- **Fixed priority:** with `SPRITE_FETCH_FIXED_PRIO_EN` defined, requesters 0 and 2 hold valid continuously. Expect requester 0 granted every time and 2 starved.

Source files
------------

// File: rtl/sprite_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_fetch_arbiter
//
// Shares the single sprite ROM (7 sprites x 1024 words, 4 pixels per word,
// fixed read latency) between several reel/overlay renderers. Each renderer
// posts a burst request (sprite, start word, length-1). One winner is picked
// per idle cycle. Its burst is issued to the ROM one word address per cycle.
// The returned words are routed back to the owner with a one-hot valid and a
// last-word flag.
//
// Configuration macro:
//   SPRITE_FETCH_FIXED_PRIO_EN  defined     -> fixed priority, lowest index wins
//                               not defined -> round-robin (default)
//
// Parameters:
//   NUM_REQ      number of requesters (2..4)
//   ROM_LATENCY  cycles from ROM address presented to rom_data_i valid (>= 1)
//
// Ports:
//   clk               system clock, rising edge
//   reset_n           asynchronous active-low reset
//   req_valid_i       per-requester request valid
//   req_ready_o       one-hot accept pulse
//   req_sprite_i      sprite index per requester, slice i = [3i+2:3i]
//   req_addr_i        start word address per requester, slice i = [10i+9:10i]
//   req_len_i         burst length minus 1 per requester, slice i = [4i+3:4i]
//   rom_sprite_sel_o  ROM sprite select (registered)
//   rom_word_addr_o   ROM word address (registered)
//   rom_data_i        ROM read data
//   rsp_valid_o       one-hot owner of rsp_data_o
//   rsp_data_o        returned word
//   rsp_last_o        final word of the burst
//   busy_o            issuing or reads still in flight
// -----------------------------------------------------------------------------
module sprite_fetch_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ROM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [3*NUM_REQ-1:0]   req_sprite_i,
  input  logic [10*NUM_REQ-1:0]  req_addr_i,
  input  logic [4*NUM_REQ-1:0]   req_len_i,
  output logic [2:0]             rom_sprite_sel_o,
  output logic [9:0]             rom_word_addr_o,
  input  logic [15:0]            rom_data_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [15:0]            rsp_data_o,
  output logic                   rsp_last_o,
  output logic                   busy_o
);

  localparam int ID_W     = (NUM_REQ > 2) ? 2 : 1;
  localparam int SUM_W    = ID_W + 1;
  localparam int TAG_LAST = ROM_LATENCY - 1;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t          state;
  logic [ID_W-1:0] burst_id;
  logic [3:0]      remaining;

  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [ID_W-1:0]    winner;
  logic [2:0]         win_sprite;
  logic [9:0]         win_addr;
  logic [3:0]         win_len;

  // One tag per ROM pipeline stage, travelling alongside the read in flight.
  logic            tag_valid [ROM_LATENCY];
  logic [ID_W-1:0] tag_id    [ROM_LATENCY];
  logic            tag_last  [ROM_LATENCY];

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef SPRITE_FETCH_FIXED_PRIO_EN
  // Scanning downward leaves the lowest valid index as the winner.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        grant_any = 1'b1;
        winner    = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0]      last_winner;
  logic [ID_W-1:0]      rr_start;
  logic [2*NUM_REQ-1:0] rr_doubled;
  logic [NUM_REQ-1:0]   rr_rotated;
  logic [ID_W-1:0]      rr_offset;
  logic [SUM_W-1:0]     rr_sum;

  // Rotate the valid vector so the search start sits at bit 0. The lowest set
  // bit of the rotated vector is then the round-robin winner, relative to the
  // start position.
  always_comb begin
    rr_start   = (last_winner == ID_W'(NUM_REQ - 1)) ? '0 : last_winner + ID_W'(1);
    rr_doubled = {req_valid_i, req_valid_i} >> rr_start;
    rr_rotated = rr_doubled[NUM_REQ-1:0];
    grant_any  = |rr_rotated;
    rr_offset  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rr_rotated[i]) begin
        rr_offset = ID_W'(i);
      end
    end
    rr_sum = {1'b0, rr_start} + {1'b0, rr_offset};
    if (rr_sum >= SUM_W'(NUM_REQ)) begin
      rr_sum = rr_sum - SUM_W'(NUM_REQ);
    end
    winner = rr_sum[ID_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_winner <= ID_W'(NUM_REQ - 1);
    end else if (state == IDLE && grant_any) begin
      last_winner <= winner;
    end
  end
`endif

  // Fetch the winner's burst fields.
  always_comb begin
    win_sprite = '0;
    win_addr   = '0;
    win_len    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_sprite = req_sprite_i[3*i +: 3];
        win_addr   = req_addr_i[10*i +: 10];
        win_len    = req_len_i[4*i +: 4];
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = grant_any && (winner == ID_W'(i));
    end
  end

  // Accept is combinational so a requester that drops valid is never granted.
  // It is gated by reset_n so every output reads 0 while reset is held.
  assign req_ready_o = (state == IDLE && reset_n) ? grant : '0;

  // ---------------------------------------------------------------------------
  // Burst FSM. The first ROM address is loaded on the accept edge. Each ISSUE
  // cycle therefore presents the word being issued, and the edge that ends the
  // cycle advances to the next one. Address arithmetic wraps mod 1024 within
  // the same sprite.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      burst_id         <= '0;
      remaining        <= '0;
      rom_sprite_sel_o <= '0;
      rom_word_addr_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state            <= ISSUE;
            burst_id         <= winner;
            remaining        <= win_len;
            rom_sprite_sel_o <= win_sprite;
            rom_word_addr_o  <= win_addr;
          end
        end
        ISSUE: begin
          if (remaining == 4'd0) begin
            state <= IDLE;
          end else begin
            remaining       <= remaining - 4'd1;
            rom_word_addr_o <= rom_word_addr_o + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline. An entry enters on each ISSUE cycle, one edge after its
  // address appears at the ROM. After ROM_LATENCY stages it lines up with
  // rom_data_i.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tag_valid[i] <= 1'b0;
        tag_id[i]    <= '0;
        tag_last[i]  <= 1'b0;
      end
    end else begin
      tag_valid[0] <= (state == ISSUE);
      tag_id[0]    <= burst_id;
      tag_last[0]  <= (state == ISSUE) && (remaining == 4'd0);
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
    end
  end

  // Response routing. The data is passed straight through from the ROM. It is
  // zeroed when no tagged word is present.
  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = tag_valid[TAG_LAST] && (tag_id[TAG_LAST] == ID_W'(i));
    end
  end

  assign rsp_last_o = tag_valid[TAG_LAST] && tag_last[TAG_LAST];
  assign rsp_data_o = tag_valid[TAG_LAST] ? rom_data_i : '0;

  always_comb begin
    busy_o = (state == ISSUE);
    for (int i = 0; i < ROM_LATENCY; i++) begin
      busy_o = busy_o || tag_valid[i];
    end
  end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_fetch_arbiter
//
// Testbench for sprite_fetch_arbiter. A behavioural ROM with the configured
// latency drives rom_data_i. A cycle-indexed reference model derives the
// expected results from the burst rules:
//   - the expected accept pulse
//   - the ROM address and sprite for every issue cycle
//   - the owner, data and last flag for every response cycle
//   - busy
// Directed steps cover contention, fairness, a single row burst, address wrap,
// sprite 7 and reset mid-burst. A randomized traffic phase follows.
// Honours SPRITE_FETCH_FIXED_PRIO_EN for the expected grant order.
// -----------------------------------------------------------------------------
module tb_sprite_fetch_arbiter;

  localparam int NUM_REQ     = 3;
  localparam int ROM_LATENCY = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [3*NUM_REQ-1:0]  req_sprite_i;
  logic [10*NUM_REQ-1:0] req_addr_i;
  logic [4*NUM_REQ-1:0]  req_len_i;
  logic [2:0]            rom_sprite_sel_o;
  logic [9:0]            rom_word_addr_o;
  logic [15:0]           rom_data_i;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic [15:0]           rsp_data_o;
  logic                  rsp_last_o;
  logic                  busy_o;

  always #5 clk = ~clk;

  sprite_fetch_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ROM_LATENCY (ROM_LATENCY)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_sprite_i     (req_sprite_i),
    .req_addr_i       (req_addr_i),
    .req_len_i        (req_len_i),
    .rom_sprite_sel_o (rom_sprite_sel_o),
    .rom_word_addr_o  (rom_word_addr_o),
    .rom_data_i       (rom_data_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_data_o       (rsp_data_o),
    .rsp_last_o       (rsp_last_o),
    .busy_o           (busy_o)
  );

  // Sprite 7 reads as zero. Other words carry a pattern built from sprite and
  // address, and that pattern is never zero.
  function automatic logic [15:0] romWord(input logic [2:0] s, input logic [9:0] a);
    if (s == 3'd7) return 16'h0000;
    return {s, a, 3'b000} ^ 16'h5A3C;
  endfunction

  // Behavioural ROM: the address is captured on each edge and the data
  // appears ROM_LATENCY cycles after the address was presented.
  logic [12:0] romPipe [ROM_LATENCY];
  always @(posedge clk) begin
    romPipe[0] <= {rom_sprite_sel_o, rom_word_addr_o};
    for (int i = 1; i < ROM_LATENCY; i++) romPipe[i] <= romPipe[i-1];
  end
  assign rom_data_i = romWord(romPipe[ROM_LATENCY-1][12:10], romPipe[ROM_LATENCY-1][9:0]);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state, indexed by cycle number.
  int          idleAt  = 0;
  int          lastWin = NUM_REQ - 1;
  int          expAddr    [int];
  int          expSpr     [int];
  int          expRspId   [int];
  bit          expRspLast [int];
  logic [15:0] expRspData [int];
  bit          expBusy    [int];

  // Requester behaviour.
  logic       rqValid [NUM_REQ];
  logic [2:0] rqSpr   [NUM_REQ];
  logic [9:0] rqAddr  [NUM_REQ];
  logic [3:0] rqLen   [NUM_REQ];
  bit         renew   [NUM_REQ];
  bit         randomMode = 1'b0;

  int dutGrants[$];
  int dutGrantCyc[$];
  int fairExp [4];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic driveInputs();
    for (int r = 0; r < NUM_REQ; r++) begin
      req_valid_i[r]         = rqValid[r];
      req_sprite_i[3*r +: 3]  = rqSpr[r];
      req_addr_i[10*r +: 10]  = rqAddr[r];
      req_len_i[4*r +: 4]     = rqLen[r];
    end
  endtask

  task automatic applyStimulus(input int r, input logic [2:0] spr, input logic [9:0] addr,
                               input logic [3:0] len);
    rqValid[r] = 1'b1;
    rqSpr[r]   = spr;
    rqAddr[r]  = addr;
    rqLen[r]   = len;
    driveInputs();
  endtask

  task automatic newReq(input int r);
    logic [9:0] a;
    a = 10'($urandom_range(0, 1023));
    if ($urandom_range(0, 3) == 0) a = 10'(1020 + $urandom_range(0, 3));
    applyStimulus(r, 3'($urandom_range(0, 7)), a, 4'($urandom_range(0, 15)));
  endtask

  function automatic int pickWinner();
    if (cyc < idleAt) return -1;
`ifdef SPRITE_FETCH_FIXED_PRIO_EN
    for (int r = 0; r < NUM_REQ; r++) if (rqValid[r]) return r;
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (lastWin + k) % NUM_REQ;
      if (rqValid[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  // Record the consequences of accepting requester w in the current cycle.
  task automatic acceptModel(input int w);
    int t;
    int n;
    t = cyc;
    n = int'(rqLen[w]);
    for (int k = 0; k <= n; k++) begin
      logic [9:0] a;
      a = 10'((int'(rqAddr[w]) + k) % 1024);
      expAddr[t + 1 + k]                  = int'(a);
      expSpr[t + 1 + k]                   = int'(rqSpr[w]);
      expRspId[t + 1 + ROM_LATENCY + k]   = w;
      expRspLast[t + 1 + ROM_LATENCY + k] = (k == n);
      expRspData[t + 1 + ROM_LATENCY + k] = romWord(rqSpr[w], a);
    end
    for (int c = t + 1; c <= t + 1 + ROM_LATENCY + n; c++) expBusy[c] = 1'b1;
    idleAt  = t + 2 + n;
    lastWin = w;
  endtask

  task automatic clearModel();
    expAddr.delete();
    expSpr.delete();
    expRspId.delete();
    expRspLast.delete();
    expRspData.delete();
    expBusy.delete();
  endtask

  task automatic checkCycle(output int acc);
    logic [NUM_REQ-1:0] expReady;
    int w;
    w = pickWinner();
    expReady = (w >= 0) ? (NUM_REQ'(1) << w) : '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (req_ready_o[r] === 1'b1) begin
        dutGrants.push_back(r);
        dutGrantCyc.push_back(cyc);
      end
    end
    checkOutput("ready", 32'(req_ready_o), 32'(expReady));
    if (expAddr.exists(cyc)) begin
      checkOutput("rom_addr", 32'(rom_word_addr_o), 32'(expAddr[cyc]));
      checkOutput("rom_sprite", 32'(rom_sprite_sel_o), 32'(expSpr[cyc]));
    end
    if (expRspId.exists(cyc)) begin
      checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(NUM_REQ'(1) << expRspId[cyc]));
      checkOutput("rsp_last", 32'(rsp_last_o), 32'(expRspLast[cyc]));
      checkOutput("rsp_data", 32'(rsp_data_o), 32'(expRspData[cyc]));
    end else begin
      checkOutput("rsp_valid_idle", 32'(rsp_valid_o), 32'd0);
      checkOutput("rsp_last_idle", 32'(rsp_last_o), 32'd0);
    end
    checkOutput("busy", 32'(busy_o), 32'(expBusy.exists(cyc)));
    if (w >= 0) acceptModel(w);
    acc = w;
  endtask

  task automatic randomTraffic(input int acc);
    for (int r = 0; r < NUM_REQ; r++) begin
      if (r != acc) begin
        if (!rqValid[r]) begin
          if ($urandom_range(0, 3) == 0) newReq(r);
        end else if ($urandom_range(0, 31) == 0) begin
          rqValid[r] = 1'b0;
        end
      end
    end
    driveInputs();
  endtask

  task automatic runCycle();
    int acc;
    @(negedge clk);
    checkCycle(acc);
    @(posedge clk);
    #1;
    cyc++;
    if (acc >= 0) begin
      if (renew[acc]) newReq(acc);
      else rqValid[acc] = 1'b0;
    end
    if (randomMode) randomTraffic(acc);
    driveInputs();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(req_ready_o), 32'd0);
    checkOutput({tag, "_rspvalid"}, 32'(rsp_valid_o), 32'd0);
    checkOutput({tag, "_rsplast"}, 32'(rsp_last_o), 32'd0);
    checkOutput({tag, "_rspdata"}, 32'(rsp_data_o), 32'd0);
    checkOutput({tag, "_romaddr"}, 32'(rom_word_addr_o), 32'd0);
    checkOutput({tag, "_romspr"}, 32'(rom_sprite_sel_o), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic dropAll();
    for (int r = 0; r < NUM_REQ; r++) begin
      rqValid[r] = 1'b0;
      renew[r]   = 1'b0;
    end
    driveInputs();
  endtask

  initial begin
    int base;
`ifdef SPRITE_FETCH_FIXED_PRIO_EN
    fairExp = '{0, 0, 0, 0};
`else
    fairExp = '{0, 2, 0, 2};
`endif
    for (int r = 0; r < NUM_REQ; r++) begin
      rqValid[r] = 1'b0;
      rqSpr[r]   = '0;
      rqAddr[r]  = '0;
      rqLen[r]   = '0;
      renew[r]   = 1'b0;
    end
    driveInputs();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
    idleAt  = 0;
    lastWin = NUM_REQ - 1;

    // Contention: all three requesters, single-word bursts.
    base = dutGrants.size();
    applyStimulus(0, 3'd1, 10'h020, 4'd0);
    applyStimulus(1, 3'd2, 10'h040, 4'd0);
    applyStimulus(2, 3'd3, 10'h060, 4'd0);
    runCycles(10);
    checkOutput("contend_count", 32'(dutGrants.size() - base), 32'd3);
    checkOutput("contend_g0", 32'(dutGrants[base]), 32'd0);
    checkOutput("contend_g1", 32'(dutGrants[base+1]), 32'd1);
    checkOutput("contend_g2", 32'(dutGrants[base+2]), 32'd2);
    checkOutput("contend_gap1", 32'(dutGrantCyc[base+1] - dutGrantCyc[base]), 32'd2);
    checkOutput("contend_gap2", 32'(dutGrantCyc[base+2] - dutGrantCyc[base+1]), 32'd2);

    // Fairness: requesters 0 and 2 hold valid continuously.
    base = dutGrants.size();
    applyStimulus(0, 3'd1, 10'h100, 4'd1);
    applyStimulus(2, 3'd3, 10'h200, 4'd1);
    renew[0] = 1'b1;
    renew[2] = 1'b1;
    for (int i = 0; i < 200 && (dutGrants.size() - base) < 4; i++) runCycle();
    checkOutput("fair_count", 32'(dutGrants.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput("fair_order", 32'(dutGrants[base+i]), 32'(fairExp[i]));
    dropAll();
    runCycles(25);

    // Single 16-word row burst from requester 1.
    base = dutGrants.size();
    applyStimulus(1, 3'd2, 10'h010, 4'd15);
    runCycles(25);
    checkOutput("single_count", 32'(dutGrants.size() - base), 32'd1);
    checkOutput("single_owner", 32'(dutGrants[base]), 32'd1);

    // Address wrap within the sprite, then the empty sprite 7.
    applyStimulus(0, 3'd5, 10'h3FE, 4'd3);
    runCycles(12);
    applyStimulus(2, 3'd7, 10'h123, 4'd2);
    runCycles(12);

    // Reset asserted in the 5th issue cycle of a 16-word burst.
    applyStimulus(0, 3'd4, 10'h050, 4'd15);
    runCycle();
    applyStimulus(1, 3'd6, 10'h200, 4'd0);
    runCycles(4);
    #1;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    clearModel();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc++;
    idleAt  = cyc;
    lastWin = NUM_REQ - 1;
    base = dutGrants.size();
    runCycle();
    checkOutput("postrst_grant", 32'(dutGrants.size() - base), 32'd1);
    runCycles(25);

    // Randomized traffic.
    randomMode = 1'b1;
    runCycles(3000);
    randomMode = 1'b0;
    dropAll();
    runCycles(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
